// File: rtl/prrty_res.sv
// ---------------------------------------------------------------------------
// prrty_res -- priority resolver with in-service tracking and rotation.
//
// Eight interrupt request lines are ranked by a rotating lowest-priority
// pointer lp. Priority descends from IR(lp+1 mod 8) down to IR(lp). Reset
// leaves lp = 7, so IR0 is the highest priority and IR7 the lowest.
//
// Ports
//   clk      in   rising-edge clock for all state
//   rst      in   synchronous active-high reset
//   fn       in   special fully nested: a same-level request may interrupt
//   ar       in   automatic rotate: on EOI, the serviced level becomes lowest
//   eoi      in   non-specific end of interrupt (level, rising edge acts)
//   inta     in   interrupt acknowledge (level, rising edge acts)
//   irr[7:0] in   interrupt request register
//   imr[7:0] in   interrupt mask register (1 = masked)
//   isr[7:0] out  in-service register (registered)
//   isprior  out  combinational INT request: an unmasked request outranks
//                 the level currently in service
// ---------------------------------------------------------------------------
module prrty_res (
    input  logic       clk,
    input  logic       rst,
    input  logic       fn,
    input  logic       ar,
    input  logic       eoi,
    input  logic       inta,
    input  logic [7:0] irr,
    input  logic [7:0] imr,
    output logic [7:0] isr,
    output logic       isprior
);

    logic [7:0] isr_reg, isr_next;
    logic [2:0] lp_reg, lp_next;
    logic       inta_reg;
    logic       eoi_reg;

    logic [7:0] cand;
    logic [7:0] cand_rot;
    logic [7:0] isr_rot;
    logic [2:0] h_rank, s_rank;
    logic [2:0] h_idx, s_idx;
    logic       cand_any, isr_any;
    logic       ack_ev, eoi_ev;

    assign cand     = irr & ~imr;
    assign cand_any = |cand;
    assign isr_any  = |isr_reg;

    // Rotate both vectors so that position 0 holds the highest-priority
    // level; a plain lowest-index-first search then yields the rank.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_rot
            assign cand_rot[gi] = cand[lp_reg + 3'(gi + 1)];
            assign isr_rot[gi]  = isr_reg[lp_reg + 3'(gi + 1)];
        end
    endgenerate

    // Rank 0 is the highest priority. Scanning downwards lets the lowest
    // set index win. An empty vector yields rank 0, but every consumer
    // below qualifies the rank with the matching *_any flag.
    always_comb begin
        h_rank = 3'd0;
        s_rank = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (cand_rot[i]) h_rank = 3'(i);
            if (isr_rot[i])  s_rank = 3'(i);
        end
    end

    // Map each rank back to its physical IR number.
    assign h_idx = lp_reg + 3'd1 + h_rank;
    assign s_idx = lp_reg + 3'd1 + s_rank;

    // A lower rank is a higher priority. In special fully nested mode, an
    // equal rank also wins.
    always_comb begin
        isprior = 1'b0;
        if (cand_any) begin
            if (!isr_any)
                isprior = 1'b1;
            else if (fn)
                isprior = (h_rank <= s_rank);
            else
                isprior = (h_rank < s_rank);
        end
    end

    assign ack_ev = inta & ~inta_reg;
    assign eoi_ev = eoi & ~eoi_reg;

    // The clear is applied before the set. When both events fall on one
    // edge, the result is (isr & ~s) | h, with h and s taken from the
    // pre-edge state.
    always_comb begin
        isr_next = isr_reg;
        lp_next  = lp_reg;
        if (eoi_ev && isr_any) begin
            isr_next[s_idx] = 1'b0;
            if (ar)
                lp_next = s_idx;
        end
        if (ack_ev && cand_any)
            isr_next[h_idx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            isr_reg  <= 8'h00;
            lp_reg   <= 3'd7;
            inta_reg <= 1'b0;
            eoi_reg  <= 1'b0;
        end else begin
            isr_reg  <= isr_next;
            lp_reg   <= lp_next;
            inta_reg <= inta;
            eoi_reg  <= eoi;
        end
    end

    assign isr = isr_reg;

endmodule

// File: tb/tb_prrty_res.sv
module tb_prrty_res;

    logic       clk = 1'b0;
    logic       rst;
    logic       fn, ar, eoi, inta;
    logic [7:0] irr, imr;
    logic [7:0] isr;
    logic       isprior;

    int passed = 0;
    int total  = 0;

    prrty_res dut (
        .clk     (clk),
        .rst     (rst),
        .fn      (fn),
        .ar      (ar),
        .eoi     (eoi),
        .inta    (inta),
        .irr     (irr),
        .imr     (imr),
        .isr     (isr),
        .isprior (isprior)
    );

    always #5 clk = ~clk;

    // Advance one clock edge, then settle 1 ns past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic pulse_inta();
        inta = 1'b1;
        step();
        inta = 1'b0;
        step();
    endtask

    task automatic pulse_eoi();
        eoi = 1'b1;
        step();
        eoi = 1'b0;
        step();
    endtask

    initial begin
        rst = 1'b1; fn = 1'b1; ar = 1'b1; eoi = 1'b1; inta = 1'b1;
        irr = 8'hAA; imr = 8'hFF;

        // Reset overrides events; all requests masked.
        step();
        check("rst_isr", isr, 8'h00);
        check("rst_isprior", {7'd0, isprior}, 8'h00);
        rst = 1'b0;
        step();
        step();
        check("masked_isr", isr, 8'h00);
        check("masked_isprior", {7'd0, isprior}, 8'h00);

        // Normal nesting, acknowledge.
        fn = 1'b0; ar = 1'b0; eoi = 1'b0; inta = 1'b0;
        do_reset();
        imr = 8'h00; irr = 8'hAA;
        step();
        check("aa_isprior", {7'd0, isprior}, 8'h01);
        pulse_inta();
        check("ack1_isr", isr, 8'h02);
        check("same_lvl_isprior", {7'd0, isprior}, 8'h00);
        irr = 8'h03;
        #1;
        check("ir0_isprior", {7'd0, isprior}, 8'h01);
        pulse_inta();
        check("ack2_isr", isr, 8'h03);

        // EOI without rotation.
        pulse_eoi();
        check("eoi1_isr", isr, 8'h02);
        pulse_eoi();
        check("eoi2_isr", isr, 8'h00);
        irr = 8'h81;
        pulse_inta();
        check("lp7_kept_isr", isr, 8'h01);
        pulse_eoi();
        check("eoi3_isr", isr, 8'h00);

        // Rotation on EOI.
        irr = 8'h08;
        pulse_inta();
        check("ack_ir3_isr", isr, 8'h08);
        ar = 1'b1;
        pulse_eoi();
        ar = 1'b0;
        check("rot_eoi_isr", isr, 8'h00);
        irr = 8'h11;
        #1;
        check("rot_isprior", {7'd0, isprior}, 8'h01);
        pulse_inta();
        check("rot_ack_isr", isr, 8'h10);
        check("rot_same_isprior", {7'd0, isprior}, 8'h00);
        irr = 8'h01; fn = 1'b1;
        #1;
        check("rot_lower_isprior", {7'd0, isprior}, 8'h00);
        fn = 1'b0;

        // Reset mid-service discards the service state and the rotation.
        irr = 8'h11;
        do_reset();
        step();
        check("midrst_isr", isr, 8'h00);
        pulse_inta();
        check("midrst_lp_isr", isr, 8'h01);

        // Special fully nested.
        do_reset();
        irr = 8'h04; imr = 8'h00;
        pulse_inta();
        check("ir2_isr", isr, 8'h04);
        fn = 1'b1; #1;
        check("sfn_isprior", {7'd0, isprior}, 8'h01);
        fn = 1'b0; #1;
        check("fn0_isprior", {7'd0, isprior}, 8'h00);
        imr = 8'h04; #1;
        check("mask_fn0_isprior", {7'd0, isprior}, 8'h00);
        fn = 1'b1; #1;
        check("mask_fn1_isprior", {7'd0, isprior}, 8'h00);
        irr = 8'hFF; imr = 8'h00;
        step();
        check("irr_no_isr_change", isr, 8'h04);
        fn = 1'b0;

        // Simultaneous acknowledge and EOI, then hold both high.
        do_reset();
        irr = 8'h02;
        pulse_inta();
        check("ir1_isr", isr, 8'h02);
        irr = 8'h01;
        inta = 1'b1; eoi = 1'b1;
        step();
        check("simul_isr", isr, 8'h01);
        step(); step(); step();
        check("hold_isr", isr, 8'h01);
        inta = 1'b0; eoi = 1'b0;
        step();
        check("release_isr", isr, 8'h01);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    // Safety net: the directed sequence is far shorter than this.
    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
